// File: rtl/i2c_slave_receiver.sv
// Write-only I2C slave: synchronises SCL/SDA, detects START/STOP, matches a
// 7-bit address, ACKs address and data bytes, and strobes out each data byte.
module i2c_slave_receiver #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       ADDR_HIT,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_hit_q, addr_hit_d;
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & ~sda_prev_q & sda_s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL_IN};
      sda_sync_q <= {sda_sync_q[0], SDA_IN};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    addr_hit_d = 1'b0;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;

    if (!EN || start_c || stop_c) begin
      state_d  = (EN && start_c) ? S_ADDR : S_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_d[7:1] == SLAVE_ADDR && !shift_d[0]) begin
                state_d    = S_ADDR_ACK;
                addr_hit_d = 1'b1;
                busy_d     = 1'b1;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = shift_d;
              rx_valid_d = 1'b1;
              state_d    = S_DATA_ACK;
            end
          end
        end
        // First SCL fall after the 8th bit starts driving ACK; the next fall
        // (end of the 9th clock) releases it. The 9th rising edge is not a bit.
        S_ADDR_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_DATA;
              cnt_d    = '0;
            end
          end
        end
        S_IDLE, S_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign SDA_OE   = sda_oe_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign ADDR_HIT = addr_hit_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Bench for i2c_slave_receiver: drives an I2C master on an open-drain bus model
// and checks ACKs, strobes and received bytes against a transfer-level model.
module tb_i2c_slave_receiver;

  localparam int unsigned Q = 10;
  localparam int unsigned H = 5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       SDA_OE;
  logic [7:0] RX_DATA;
  logic       RX_VALID, ADDR_HIT, BUSY;
  logic       sda_bus;

  assign sda_bus = sda_m & ~SDA_OE;

  i2c_slave_receiver #(.SLAVE_ADDR(7'h42)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .SCL_IN(scl), .SDA_IN(sda_bus),
    .SDA_OE(SDA_OE), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ADDR_HIT(ADDR_HIT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned hits_seen = 0, exp_hits = 0, stray_oe = 0;
  logic        ack_window = 1'b0;
  logic [7:0]  got_q[$], exp_q[$];
  logic [7:0]  last_rx = 8'h00;
  logic [7:0]  tx[0:7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RX_VALID) got_q.push_back(RX_DATA);
    if (ADDR_HIT) hits_seen++;
    if (SDA_OE && !ack_window) stray_oe++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_start();
    wait_clk(H); sda_m = 1'b1; wait_clk(H); scl = 1'b1;
    wait_clk(Q); sda_m = 1'b0; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(H); sda_m = 1'b0; wait_clk(H); scl = 1'b1;
    wait_clk(Q); sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned n);
    for (int i = 7; i > 7 - int'(n); i--) begin
      wait_clk(H); sda_m = b[i]; wait_clk(H); scl = 1'b1; wait_clk(Q); scl = 1'b0;
    end
  endtask

  // Ninth clock with master released; ACK means OE held across the whole high phase.
  task automatic ack_clk(output logic ack);
    logic a0;
    ack_window = 1'b1;
    wait_clk(H); sda_m = 1'b1; wait_clk(H); scl = 1'b1;
    wait_clk(Q / 2); a0 = SDA_OE;
    wait_clk(Q / 2 - 1); ack = a0 & SDA_OE & ~sda_bus;
    wait_clk(1); scl = 1'b0;
    wait_clk(4); ack_window = 1'b0;
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_rxcount"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_rxbyte"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
    check({tag, "_hits"}, hits_seen, exp_hits);
    check({tag, "_stray_oe"}, stray_oe, 0);
    check({tag, "_rxhold"}, RX_DATA, last_rx);
  endtask

  // Model: a write addressed to 0x42 is ACKed byte by byte and every complete
  // data byte is delivered; anything else is ignored until the next condition.
  task automatic run_xfer(input string tag, input logic [7:0] ab, input int unsigned nbytes,
                          input int unsigned trunc, input logic with_stop);
    logic ack, hit;
    hit = (ab[7:1] == 7'h42) && !ab[0];
    bus_start();
    check({tag, "_busy_start"}, BUSY, 0);
    send_bits(ab, 8);
    ack_clk(ack);
    check({tag, "_addr_ack"}, ack, hit);
    check({tag, "_busy"}, BUSY, hit);
    if (hit) exp_hits++;
    for (int i = 0; i < int'(nbytes); i++) begin
      send_bits(tx[i], 8);
      ack_clk(ack);
      check({tag, "_data_ack"}, ack, hit);
      if (hit) begin
        exp_q.push_back(tx[i]);
        last_rx = tx[i];
      end
    end
    if (trunc > 0) send_bits(tx[nbytes], trunc);
    if (with_stop) begin
      bus_stop();
      check({tag, "_busy_stop"}, BUSY, 0);
    end
    compare_rx(tag);
  endtask

  initial begin
    logic ack;
    int unsigned guard;
    wait_clk(3);
    check("rst_oe", SDA_OE, 0);
    check("rst_rxdata", RX_DATA, 8'h00);
    check("rst_valid", RX_VALID, 0);
    check("rst_hit", ADDR_HIT, 0);
    check("rst_busy", BUSY, 0);
    RESET = 1'b0;
    wait_clk(5);

    tx[0] = 8'hA5;
    run_xfer("t1", 8'h84, 1, 0, 1'b1);
    tx[0] = 8'h11;
    run_xfer("t2", 8'h86, 1, 0, 1'b1);
    run_xfer("t3", 8'h85, 0, 0, 1'b1);
    tx[0] = 8'h01; tx[1] = 8'hFF; tx[2] = 8'h00;
    run_xfer("t4", 8'h84, 3, 0, 1'b1);
    tx[0] = 8'hC3;
    run_xfer("t5a", 8'h84, 0, 4, 1'b1);
    tx[0] = 8'h3C;
    run_xfer("t5b", 8'h84, 1, 0, 1'b1);
    tx[0] = 8'h9E; tx[1] = 8'h77;
    run_xfer("t5c", 8'h84, 1, 5, 1'b0);
    tx[0] = 8'h5A;
    run_xfer("t5d", 8'h84, 1, 0, 1'b1);

    // RESET asserted while the slave is driving a data ACK.
    bus_start();
    send_bits(8'h84, 8); ack_clk(ack);
    exp_hits++;
    send_bits(8'hE7, 8);
    exp_q.push_back(8'hE7);
    ack_window = 1'b1;
    guard = 0;
    while (!SDA_OE && guard < 20) begin wait_clk(1); guard++; end
    check("t6_ack_driven", SDA_OE, 1);
    RESET = 1'b1; wait_clk(1);
    check("t6_rst_oe", SDA_OE, 0);
    check("t6_rst_busy", BUSY, 0);
    RESET = 1'b0;
    last_rx = 8'h00;
    wait_clk(H); sda_m = 1'b1; wait_clk(H); scl = 1'b1; wait_clk(Q); scl = 1'b0;
    wait_clk(4); ack_window = 1'b0;
    bus_stop();
    compare_rx("t6");
    tx[0] = 8'h55;
    run_xfer("t6b", 8'h84, 1, 0, 1'b1);

    // EN dropped mid data byte: transfer abandoned, RX_DATA retained.
    bus_start();
    send_bits(8'h84, 8); ack_clk(ack);
    exp_hits++;
    send_bits(8'hF0, 3);
    EN = 1'b0; wait_clk(2);
    check("en_busy", BUSY, 0);
    check("en_oe", SDA_OE, 0);
    EN = 1'b1;
    send_bits(8'h1F, 5);
    bus_stop();
    compare_rx("en");

    for (int t = 0; t < 10; t++) begin
      logic [7:0] ab;
      int unsigned nb, tr;
      logic st;
      ab = ($urandom_range(0, 1) == 1) ? 8'h84 : 8'($urandom);
      nb = $urandom_range(0, 3);
      tr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      st = (t == 9) || ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) tx[k] = 8'($urandom);
      run_xfer("rnd", ab, nb, tr, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
